// File: rtl/scan_code_event_decoder.sv
// ---------------------------------------------------------------------------
// scan_code_event_decoder
//
// Purpose:
//   Takes validated 8-bit scan codes from the serial receiver, one per strobe.
//   It folds the 0xE0 (extended) and 0xF0 (break) prefixes into single key
//   events {extended, release, code}. The events are queued in a small
//   show-ahead FIFO that the application reads with a valid/ready handshake.
//   Codes 0x00 and 0xFF are receiver error codes. They are discarded and
//   clear any pending prefix.
//
// Optional feature (macro SCAN_EVENT_TIMEOUT_EN):
//   If TIMEOUT_CYCLES clock cycles pass without a strobe while a prefix is
//   pending, the prefix is abandoned and no event is produced. A strobe that
//   lands on the expiry cycle is processed normally.
//
// Ports:
//   control_clock    in   1             fast clock, single domain
//   reset            in   1             asynchronous, active-high
//   scan_code_in     in   8             scan code from receiver output register
//   scan_code_valid  in   1             one-cycle strobe for scan_code_in
//   event_ready      in   1             consumer accepts head event
//   event_valid      out  1             FIFO non-empty, head event presented
//   event_code       out  8             head event key code (prefixes stripped)
//   event_extended   out  1             head event was preceded by 0xE0
//   event_release    out  1             head event was preceded by 0xF0
//   fifo_count       out  ADDR_WIDTH+1  events stored, 0..FIFO_DEPTH
//   overflow         out  1             sticky: event dropped on full FIFO
// ---------------------------------------------------------------------------
module scan_code_event_decoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  control_clock,
    input  logic                  reset,
    input  logic [7:0]            scan_code_in,
    input  logic                  scan_code_valid,
    input  logic                  event_ready,
    output logic                  event_valid,
    output logic [7:0]            event_code,
    output logic                  event_extended,
    output logic                  event_release,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow
);

    // Reject illegal configurations when the design is elaborated.
    if (FIFO_DEPTH != (1 << ADDR_WIDTH) || FIFO_DEPTH < 2) begin : g_depth_check
        $error("FIFO_DEPTH must equal 2**ADDR_WIDTH and be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    state_t                  state_q, state_d;
    logic [9:0]              mem_q [FIFO_DEPTH];   // {extended, release, code}
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    overflow_q;

    logic                    push_req;
    logic [9:0]              push_entry;
    logic                    is_e0, is_f0, is_err;
    logic                    pend_ext, pend_brk;
    logic                    full, pop, do_push, drop;
    logic [9:0]              head;

`ifdef SCAN_EVENT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    tmo_expire;
`endif

    assign is_e0    = (scan_code_in == 8'hE0);
    assign is_f0    = (scan_code_in == 8'hF0);
    assign is_err   = (scan_code_in == 8'h00) || (scan_code_in == 8'hFF);
    assign pend_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    assign pend_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

`ifdef SCAN_EVENT_TIMEOUT_EN
    // The counter measures strobe-free cycles spent in a prefix state.
    // Expiry is taken only when there is no strobe, so a strobe on the
    // last cycle still completes the event.
    assign tmo_expire = (state_q != S_IDLE) && !scan_code_valid && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = '0;
        if (state_q != S_IDLE && !scan_code_valid && !tmo_expire) begin
            tmo_d = tmo_q + 1'b1;
        end
    end
`endif

    // Prefix decoding: next state and push request.
    always_comb begin
        state_d    = state_q;
        push_req   = 1'b0;
        push_entry = {pend_ext, pend_brk, scan_code_in};
        if (scan_code_valid) begin
            if (is_err) begin
                state_d = S_IDLE;
            end else if (is_e0) begin
                state_d = pend_brk ? S_EXT_BRK : S_EXT;
            end else if (is_f0) begin
                state_d = pend_ext ? S_EXT_BRK : S_BRK;
            end else begin
                push_req = 1'b1;
                state_d  = S_IDLE;
            end
        end
`ifdef SCAN_EVENT_TIMEOUT_EN
        else if (tmo_expire) begin
            state_d = S_IDLE;
        end
`endif
    end

    // FIFO control. A full FIFO still accepts a push when a pop happens
    // in the same cycle.
    assign full    = (count_q == FULL_CNT);
    assign pop     = (count_q != '0) && event_ready;
    assign do_push = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef SCAN_EVENT_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | drop;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
`ifdef SCAN_EVENT_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Show-ahead outputs come only from registered state. They are forced
    // to zero while the FIFO is empty.
    assign head           = mem_q[rd_ptr_q];
    assign event_valid    = (count_q != '0);
    assign event_code     = event_valid ? head[7:0] : '0;
    assign event_release  = event_valid & head[8];
    assign event_extended = event_valid & head[9];
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_scan_code_event_decoder.sv
module tb_scan_code_event_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code_in = '0;
    logic       scan_code_valid = 1'b0;
    logic       event_ready = 1'b0;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_release;
    logic [2:0] fifo_count;
    logic       overflow;

    scan_code_event_decoder #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .control_clock(clk),
        .reset(reset),
        .scan_code_in(scan_code_in),
        .scan_code_valid(scan_code_valid),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_code(event_code),
        .event_extended(event_extended),
        .event_release(event_release),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the event queue plus pending-prefix flags.
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ev_t;

    ev_t mq[$];
    bit  m_ext, m_brk, m_ovf;
    int  m_since;
    bit  m_pop, m_have;
    int  m_size0;
    ev_t m_ev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_since = 0;
        end else begin
            m_pop  = (mq.size() != 0) && event_ready;
            m_have = 0;
            if (scan_code_valid) begin
                m_since = 0;
                if (scan_code_in == 8'h00 || scan_code_in == 8'hFF) begin
                    m_ext = 0; m_brk = 0;
                end else if (scan_code_in == 8'hE0) begin
                    m_ext = 1;
                end else if (scan_code_in == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    m_have = 1;
                    m_ev   = '{ext: m_ext, rel: m_brk, code: scan_code_in};
                    m_ext  = 0; m_brk = 0;
                end
            end else if (m_ext || m_brk) begin
`ifdef SCAN_EVENT_TIMEOUT_EN
                m_since++;
                if (m_since >= TMO) begin
                    m_ext = 0; m_brk = 0; m_since = 0;
                end
`endif
            end
            m_size0 = mq.size();
            if (m_pop) void'(mq.pop_front());
            if (m_have) begin
                if (m_size0 < DEPTH || m_pop) mq.push_back(m_ev);
                else m_ovf = 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_valid", event_valid, mq.size() != 0);
            chk("m_count", fifo_count, mq.size());
            chk("m_ovf", overflow, m_ovf);
            chk("m_code", event_code, (mq.size() != 0) ? mq[0].code : 8'h00);
            chk("m_ext", event_extended, (mq.size() != 0) ? mq[0].ext : 1'b0);
            chk("m_rel", event_release, (mq.size() != 0) ? mq[0].rel : 1'b0);
        end
    end

    // Called at a falling edge; returns at the next falling edge, when the
    // strobed code has been processed.
    task automatic send(input logic [7:0] c);
        scan_code_in    = c;
        scan_code_valid = 1'b1;
        @(negedge clk);
        scan_code_valid = 1'b0;
        scan_code_in    = 8'h00;
    endtask

    task automatic reset_pulse();
        #1 reset = 1'b1;
        #3 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic head_is(input string name, input logic [7:0] c,
                           input logic e, input logic r);
        chk({name, "_valid"}, event_valid, 1'b1);
        chk({name, "_code"}, event_code, c);
        chk({name, "_ext"}, event_extended, e);
        chk({name, "_rel"}, event_release, r);
    endtask

    logic [7:0] tbl_code [20] = '{8'hE0, 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h5A, 8'h22,
                                  8'hFF, 8'h33, 8'hF0, 8'hE0, 8'h44, 8'h00, 8'h55, 8'h66,
                                  8'h77, 8'hE0, 8'h88, 8'h99};
    logic       tbl_rdy  [20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", event_valid, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_code", event_code, 8'h00);

        // Plain make code, then break code.
        event_ready = 1'b1;
        send(8'h1C);
        head_is("make", 8'h1C, 1'b0, 1'b0);
        chk("make_count", fifo_count, 3'd1);
        send(8'hF0);
        chk("f0_alone_valid", event_valid, 1'b0);
        send(8'h1C);
        head_is("brk", 8'h1C, 1'b0, 1'b1);

        // Extended break, then a plain code.
        send(8'hE0); send(8'hF0); send(8'h75);
        head_is("extbrk", 8'h75, 1'b1, 1'b1);
        chk("extbrk_count", fifo_count, 3'd1);
        send(8'h74);
        head_is("after_extbrk", 8'h74, 1'b0, 1'b0);

        // F0 followed by E0 also reaches extended-break; repeated prefixes hold.
        send(8'hF0); send(8'hE0); send(8'h5A);
        head_is("brk_e0", 8'h5A, 1'b1, 1'b1);
        send(8'hE0); send(8'hE0); send(8'hF0); send(8'hE0); send(8'hF0); send(8'h6B);
        head_is("repeat_pfx", 8'h6B, 1'b1, 1'b1);

        // Error codes discard pending prefixes.
        send(8'hE0); send(8'hFF); send(8'h1C);
        head_is("e0_ff", 8'h1C, 1'b0, 1'b0);
        send(8'hF0); send(8'h00); send(8'h2A);
        head_is("f0_00", 8'h2A, 1'b0, 1'b0);
        @(negedge clk);

        // Overflow: five pushes with no consumer.
        event_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", event_code, 8'h10 + 8'(i));
            @(negedge clk);
        end
        chk("ovf_empty", fifo_count, 3'd0);
        chk("ovf_sticky", overflow, 1'b1);

        // Full FIFO with a simultaneous push and pop.
        reset_pulse();
        event_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
        chk("full_count", fifo_count, 3'd4);
        scan_code_in = 8'h24; scan_code_valid = 1'b1; event_ready = 1'b1;
        @(negedge clk);
        scan_code_valid = 1'b0; event_ready = 1'b0;
        chk("fullpp_count", fifo_count, 3'd4);
        chk("fullpp_ovf", overflow, 1'b0);
        event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_drain", event_code, 8'h21 + 8'(i));
            @(negedge clk);
        end
        chk("fullpp_empty", event_valid, 1'b0);

        // Reset while a prefix is pending.
        send(8'hE0);
        reset_pulse();
        send(8'h1C);
        head_is("rst_pfx", 8'h1C, 1'b0, 1'b0);
        @(negedge clk);

        // Mixed table with consumer stalls; the model checks each cycle.
        for (int i = 0; i < 20; i++) begin
            event_ready = tbl_rdy[i];
            send(tbl_code[i]);
        end
        event_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("tbl_empty", event_valid, 1'b0);

`ifdef SCAN_EVENT_TIMEOUT_EN
        send(8'hF0);
        repeat (TMO) @(negedge clk);
        send(8'h1C);
        head_is("tmo_expired", 8'h1C, 1'b0, 1'b0);
        send(8'hF0);
        repeat (TMO - 1) @(negedge clk);
        send(8'h1C);
        head_is("tmo_edge", 8'h1C, 1'b0, 1'b1);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
